// File: rtl/rms_pkg.sv
// Shared defaults and encodings for the RMS square accumulator.
// Defaults match the downstream divider's operand width.
// Output-state encoding is shared so other blocks can decode div status.
package rms_pkg;

    localparam int RMS_SAMPLE_WIDTH = 12;
    localparam int RMS_INOUT_WIDTH  = 12;
    localparam int RMS_ACC_WIDTH    = 32;
    localparam int RMS_WINDOW_WIDTH = 10;
    localparam int RMS_SUM_SHIFT    = 4;

    typedef enum logic {
        OUT_EMPTY   = 1'b0,
        OUT_PENDING = 1'b1
    } out_state_t;

endpackage

// File: rtl/rms_sat_scale.sv
// Right-shifts a window sum and clamps it to the largest positive out_width value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input.
module rms_sat_scale #(
    parameter int in_width  = 32,
    parameter int out_width = 12,
    parameter int shift     = 4
) (
    input  logic [in_width-1:0]  in_dat,
    output logic [out_width-1:0] out_dat
);

    // Largest value the signed divider operand can hold, 2^(out_width-1)-1.
    localparam logic [in_width-1:0] max_val = in_width'((64'd1 << (out_width - 1)) - 64'd1);

    logic [in_width-1:0] shifted;

    assign shifted = in_dat >> shift;
    assign out_dat = (shifted > max_val) ? out_width'(max_val) : out_width'(shifted);

endmodule

// File: rtl/rms_square_accumulator.sv
// Squares signed samples, sums them over a programmable window and hands (sum>>shift, len) to a divider.
// Latency: div_valid rises 2 cycles after the edge that accepts the last sample of a window.
// Backpressure: div_ready consumes a pending result; a new window completing while unconsumed overwrites it and pulses overrun.
module rms_square_accumulator
    import rms_pkg::*;
#(
    parameter int sample_width = RMS_SAMPLE_WIDTH,
    parameter int inout_width  = RMS_INOUT_WIDTH,
    parameter int acc_width    = RMS_ACC_WIDTH,
    parameter int window_width = RMS_WINDOW_WIDTH,
    parameter int sum_shift    = RMS_SUM_SHIFT
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic signed [sample_width-1:0] sample,
    input  logic                           sample_valid,
    input  logic [window_width-1:0]        window_len,
    input  logic                           div_ready,
    output logic [inout_width-1:0]         numerator,
    output logic [inout_width-1:0]         denominator,
    output logic                           div_valid,
    output logic                           overrun
);

    localparam int                      sq_width = 2 * sample_width;
    localparam logic [window_width-1:0] len_one  = window_width'(1);

    // Stage 1 signals
    logic signed [sq_width-1:0] sample_ext;
    logic signed [sq_width-1:0] sq_full;
    logic [sq_width-1:0]        sq_dat;
    logic                       sq_vld;

    // Stage 2 signals
    logic [acc_width-1:0]    acc;
    logic [acc_width:0]      acc_sum;
    logic [acc_width-1:0]    acc_next;
    logic [window_width-1:0] cnt;
    logic [window_width-1:0] len_lat;
    logic [window_width-1:0] eff_len;
    logic [window_width-1:0] cur_len;
    logic                    last_sample;
    logic [acc_width-1:0]    sum_dat;
    logic [window_width-1:0] sum_len;
    logic                    sum_vld;

    // Output stage signals
    out_state_t              state;
    out_state_t              state_nxt;
    logic                    load;
    logic                    overrun_nxt;
    logic [inout_width-1:0]  scaled;

    // Sign-extend before multiplying so the square is exact in 2*sample_width bits.
    assign sample_ext = {{sample_width{sample[sample_width-1]}}, sample};
    assign sq_full    = sample_ext * sample_ext;

    // Stage 1: register the square; enable low drops any in-flight sample.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            sq_dat <= '0;
            sq_vld <= 1'b0;
        end else if (!enable) begin
            sq_vld <= 1'b0;
        end else begin
            sq_vld <= sample_valid;
            if (sample_valid) begin
                sq_dat <= $unsigned(sq_full);
            end
        end
    end

    // Window length is sampled on the first square of a window; a zero length means one.
    assign eff_len     = (window_len == '0) ? len_one : window_len;
    assign cur_len     = (cnt == '0) ? eff_len : len_lat;
    assign last_sample = (cnt == cur_len - len_one);
    assign acc_sum     = {1'b0, acc} + (acc_width + 1)'(sq_dat);
    assign acc_next    = acc_sum[acc_width] ? '1 : acc_sum[acc_width-1:0];

    // Stage 2: saturating accumulate; on the last square publish the window sum and restart.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            acc     <= '0;
            cnt     <= '0;
            len_lat <= '0;
            sum_dat <= '0;
            sum_len <= '0;
            sum_vld <= 1'b0;
        end else begin
            sum_vld <= 1'b0;
            if (!enable) begin
                acc <= '0;
                cnt <= '0;
            end else if (sq_vld) begin
                if (cnt == '0) begin
                    len_lat <= eff_len;
                end
                if (last_sample) begin
                    sum_dat <= acc_next;
                    sum_len <= cur_len;
                    sum_vld <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + len_one;
                end
            end
        end
    end

    rms_sat_scale #(
        .in_width  (acc_width),
        .out_width (inout_width),
        .shift     (sum_shift)
    ) u_sat_scale (
        .in_dat  (sum_dat),
        .out_dat (scaled)
    );

    // Output FSM state register.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output FSM: a fresh window always wins over consumption of the old one.
    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        overrun_nxt = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (sum_vld) begin
                    state_nxt = OUT_PENDING;
                    load      = 1'b1;
                end
            end
            OUT_PENDING: begin
                if (sum_vld) begin
                    load        = 1'b1;
                    overrun_nxt = !div_ready;
                end else if (div_ready) begin
                    state_nxt = OUT_EMPTY;
                end
            end
        endcase
    end

    // Result registers only change on a load, so they hold steady while pending.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            numerator   <= '0;
            denominator <= '0;
            overrun     <= 1'b0;
        end else begin
            overrun <= overrun_nxt;
            if (load) begin
                numerator   <= scaled;
                denominator <= inout_width'(sum_len);
            end
        end
    end

    assign div_valid = (state == OUT_PENDING);

endmodule

// File: doc/rms_square_accumulator.md
RMS_SQUARE_ACCUMULATOR -- requirements
Module: rms_square_accumulator

Interface
REQ-001 SHALL have parameter sample_width, default 12, signed input sample width.
REQ-002 SHALL have parameter inout_width, default 12, numerator/denominator width, matching the downstream divider.
REQ-003 SHALL have parameter acc_width, default 32, accumulator width.
REQ-004 SHALL have parameter window_width, default 10, window length width.
REQ-005 SHALL have parameter sum_shift, default 4, right shift applied to the window sum.
REQ-006 SHALL have port aclk, input, 1, the single clock.
REQ-007 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port enable, input, 1, accumulation enable.
REQ-009 SHALL have port sample, input, sample_width, signed sample.
REQ-010 SHALL have port sample_valid, input, 1, sample qualifier.
REQ-011 SHALL have port window_len, input, window_width, samples per window.
REQ-012 SHALL have port div_ready, input, 1, divider ready to accept.
REQ-013 SHALL have port numerator, output, inout_width, scaled window sum.
REQ-014 SHALL have port denominator, output, inout_width, window length used.
REQ-015 SHALL have port div_valid, output, 1, result pending.
REQ-016 SHALL have port overrun, output, 1, one-cycle pulse when a pending result is overwritten.

Function
REQ-017 Stage 1 SHALL register sample*sample as a 2*sample_width unsigned square when sample_valid and enable are high at the edge.
REQ-018 Stage 2 SHALL add each valid square to the accumulator, saturating at all-ones of acc_width.
REQ-019 Window length SHALL be latched when the sample counter is 0; window_len 0 SHALL be treated as 1.
REQ-020 When the counter reaches latched length-1 on a valid square, the SHALL load acc+square into the result, clear accumulator and counter in the same edge.
REQ-021 numerator SHALL equal (window sum >> sum_shift), saturated to 2^(inout_width-1)-1.
REQ-022 denominator SHALL equal the latched window length, zero-extended, never 0.
REQ-023 div_valid SHALL rise 2 cycles after the edge accepting the last sample of a window.
REQ-024 Output FSM SHALL have states EMPTY and PENDING; EMPTY->PENDING on window completion; PENDING->EMPTY at an edge with div_ready high and no completion.
REQ-025 numerator/denominator SHALL be held stable while PENDING.
REQ-026 Completion while PENDING and div_ready low SHALL overwrite the result, stay PENDING, pulse overrun 1 cycle.
REQ-027 Completion coincident with div_ready high SHALL load the new result, stay PENDING, no overrun.
REQ-028 enable low SHALL clear accumulator, counter and stage-1 valid; it SHALL NOT affect a PENDING result.

Reset
REQ-029 resetn low SHALL asynchronously clear numerator, denominator, div_valid, overrun, accumulator, counter, square register to 0 and FSM to EMPTY.
REQ-030 A window interrupted by reset SHALL be discarded; the first sample after release starts a new window.

Structure
REQ-031 Default widths and the EMPTY/PENDING encodings SHALL live in shared package rms_pkg.
REQ-032 Shift-and-saturate logic SHALL be sub-module rms_sat_scale; all else inline, 120-400 RTL lines.

Verification
REQ-033 window_len=4, samples 10,-10,10,-10, div_ready=1 -> numerator 25, denominator 4, div_valid 2 cycles after 4th sample.
REQ-034 window_len=4, samples 2047 x4 -> numerator 2047 (saturated), denominator 4.
REQ-035 div_ready=0, two windows of 3 samples of 4 then 8 -> overrun pulse once, numerator 12 (192>>4), div_valid held.
REQ-036 window_len=0, sample 16 -> numerator 16, denominator 1.
REQ-037 resetn low after 2 of 4 samples, then 4 samples of 4 -> numerator 4, no residue from first window.
REQ-038 enable low for 1 cycle after 2 of 4 samples, then 4 samples of 8 -> numerator 16.
